usb_ep_buffer: RTL and testbench
================================

Name: usb_ep_buffer

Overview:
- Parametrised multi-endpoint successor to the single 64-byte USB data buffer that sits between the AHB slave and the USB transmitter/receiver.
- Provides NUM_EP independent circular FIFOs.
- The host (AHB) side and the USB (rx/tx) side each address one endpoint per cycle through their own endpoint selects.
- Adds per-endpoint occupancy, full/empty status, and sticky overflow/underflow flags, which the single buffer lacks.

Parameters:
NUM_EP, 4, number of endpoint FIFOs (1..16)
DEPTH, 64, entries per FIFO; power of two, >=2
DATA_W, 8, data width in bits
Derived, not a parameter: OCC_W = $clog2(DEPTH+1); EP_W = max(1, $clog2(NUM_EP))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
host_ep  in  EP_W  endpoint addressed by host-side operations
store_tx_data  in  1  host write strobe
tx_data  in  DATA_W  host write data
get_rx_data  in  1  host read (pop) strobe
rx_data  out  DATA_W  head entry of FIFO[host_ep], combinational
clear  in  1  host-side reset of FIFO[host_ep]
usb_ep  in  EP_W  endpoint addressed by USB-side operations
store_rx_packet_data  in  1  USB receiver write strobe
rx_packet_data  in  DATA_W  USB receiver write data
get_tx_packet_data  in  1  USB transmitter pop strobe
tx_packet_data  out  DATA_W  head entry of FIFO[usb_ep], combinational
flush  in  1  USB-side reset of FIFO[usb_ep]
err_clr  in  1  clears all sticky error flags
host_occupancy  out  OCC_W  count of FIFO[host_ep]
buffer_occupancy  out  OCC_W  count of FIFO[usb_ep]
occupancy_all  out  NUM_EP*OCC_W  all counts; EP i occupies bits [i*OCC_W +: OCC_W]
empty  out  NUM_EP  per-endpoint count==0
full  out  NUM_EP  per-endpoint count==DEPTH
ovf_err  out  NUM_EP  sticky: a write was rejected
udf_err  out  NUM_EP  sticky: a pop was rejected

Behaviour:
- Reset (rst high, asynchronous): all wptr, rptr and count = 0; ovf_err = 0, udf_err = 0; empty = all 1s, full = 0; all occupancies = 0.
  - Storage contents are not reset.
  - rx_data and tx_packet_data = 0 while the addressed FIFO is empty.
- Per-endpoint state: wptr and rptr (log2 DEPTH bits, wrap naturally at DEPTH), plus count (OCC_W bits).
  - Entry address = ep*DEPTH + ptr.
- Reads are first-word-fall-through, with zero latency:
  - rx_data = mem[host_ep][rptr] when count > 0, else 0; tx_packet_data behaves the same for usb_ep.
  - A pop advances rptr on the next rising edge.
- Writes take effect on the rising edge and are visible at the head in the following cycle when the FIFO was empty.
- Per endpoint e per cycle:
  - Candidate writes: host (store_tx_data && host_ep==e) and USB (store_rx_packet_data && usb_ep==e).
  - Candidate pops: host (get_rx_data && host_ep==e) and USB (get_tx_packet_data && usb_ep==e).
- Same-endpoint conflicts:
  - Two writes to e in one cycle: the USB write is accepted, the host write is dropped, and ovf_err[e] is set.
  - Two pops of e in one cycle: the USB pop is accepted, the host pop is dropped, and udf_err[e] is set.
- Accepted write when count==DEPTH:
  - With no accepted pop the same cycle, the write is ignored and ovf_err[e] is set.
  - With an accepted pop the same cycle, the write succeeds and count stays DEPTH.
- Pop when count==0: ignored and udf_err[e] is set. A same-cycle write is still accepted, giving count = 1.
- Normal case: count_next = count + accepted_write - accepted_pop; count never exceeds DEPTH and never underflows.
- clear (on host_ep) and flush (on usb_ep):
  - Set wptr, rptr and count of the targeted endpoint to 0, and clear its ovf_err/udf_err bits.
  - Override every same-cycle write, pop and error set on that endpoint.
  - clear and flush on different endpoints act independently.
- err_clr zeroes all error bits.
  - An error set and err_clr in the same cycle: the error set wins.
- Out-of-range ep select (>= NUM_EP): writes and pops are ignored with no flag set, and the read data port returns 0.
- Status outputs (empty, full, occupancies) are derived combinationally from the registered counts.

Test Plan:
- Reset, then write 0x11,0x22,0x33 via host to EP1 -> host_occupancy=3 when host_ep=1; three USB pops (usb_ep=1) return 0x11,0x22,0x33 on tx_packet_data; empty[1]=1 afterwards.
- Fill EP2 with 64 USB writes, then one more write -> full[2]=1, count stays 64, ovf_err[2]=1; then a simultaneous write+pop at full -> count stays 64, no new error.
- In one cycle, a host write of 0xAA and a USB write of 0x55 to EP0 -> only 0x55 stored, count=1, ovf_err[0]=1; other endpoints unchanged.
- Pop EP3 while empty, with a same-cycle write of 0x7E -> udf_err[3]=1, count=1, head=0x7E; then err_clr -> udf_err=0.
- Write 130 entries to EP1 while popping in an interleaved pattern (wraparound past 64) -> data order preserved and occupancy_all bits [1*7 +: 7] always match the reference model.
- 10 entries in EP0, 5 in EP1; flush with usb_ep=0 and a same-cycle host write to EP0 -> EP0 count=0, EP1 still 5; rst asserted mid-burst -> all counts 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/usb_ep_buffer.sv
// Multi-endpoint USB data buffer: NUM_EP independent circular FIFOs shared by a host
// side and a USB side, with per-endpoint occupancy, full/empty and sticky error flags.
module usb_ep_buffer #(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1),
    localparam int unsigned EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [EP_W-1:0]         host_ep,
    input  logic                    store_tx_data,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic                    get_rx_data,
    output logic [DATA_W-1:0]       rx_data,
    input  logic                    clear,
    input  logic [EP_W-1:0]         usb_ep,
    input  logic                    store_rx_packet_data,
    input  logic [DATA_W-1:0]       rx_packet_data,
    input  logic                    get_tx_packet_data,
    output logic [DATA_W-1:0]       tx_packet_data,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [OCC_W-1:0]        host_occupancy,
    output logic [OCC_W-1:0]        buffer_occupancy,
    output logic [NUM_EP*OCC_W-1:0] occupancy_all,
    output logic [NUM_EP-1:0]       empty,
    output logic [NUM_EP-1:0]       full,
    output logic [NUM_EP-1:0]       ovf_err,
    output logic [NUM_EP-1:0]       udf_err
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ADDR_W = EP_W + PTR_W;

    logic [DATA_W-1:0] mem_q [NUM_EP*DEPTH];

    logic [PTR_W-1:0]  wptr_q  [NUM_EP];
    logic [PTR_W-1:0]  wptr_d  [NUM_EP];
    logic [PTR_W-1:0]  rptr_q  [NUM_EP];
    logic [PTR_W-1:0]  rptr_d  [NUM_EP];
    logic [OCC_W-1:0]  count_q [NUM_EP];
    logic [OCC_W-1:0]  count_d [NUM_EP];
    logic [NUM_EP-1:0] ovf_q, ovf_d, udf_q, udf_d;

    logic [NUM_EP-1:0] host_hit, usb_hit;
    logic [NUM_EP-1:0] wr_h, wr_u, pop_h, pop_u;
    logic [NUM_EP-1:0] wr_ok, pop_ok, ovf_set, udf_set, ep_rst, mem_we;
    logic [DATA_W-1:0] wdata [NUM_EP];

    // Endpoint decode; out-of-range selects match nothing
    always_comb begin
        host_hit = '0;
        usb_hit  = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            host_hit[e] = (host_ep == EP_W'(e));
            usb_hit[e]  = (usb_ep == EP_W'(e));
        end
    end

    assign wr_h  = store_tx_data        ? host_hit : '0;
    assign wr_u  = store_rx_packet_data ? usb_hit  : '0;
    assign pop_h = get_rx_data          ? host_hit : '0;
    assign pop_u = get_tx_packet_data   ? usb_hit  : '0;

    // Arbitration: USB side wins same-endpoint conflicts; a pop frees room for a write at full
    always_comb begin
        wr_ok   = '0;
        pop_ok  = '0;
        ovf_set = '0;
        udf_set = '0;
        ep_rst  = '0;
        mem_we  = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            wdata[e]   = wr_u[e] ? rx_packet_data : tx_data;
            ep_rst[e]  = (clear && host_hit[e]) || (flush && usb_hit[e]);
            pop_ok[e]  = (pop_h[e] || pop_u[e]) && (count_q[e] != '0);
            wr_ok[e]   = (wr_h[e] || wr_u[e]) && ((count_q[e] != OCC_W'(DEPTH)) || pop_ok[e]);
            ovf_set[e] = (wr_h[e] && wr_u[e]) || ((wr_h[e] || wr_u[e]) && !wr_ok[e]);
            udf_set[e] = (pop_h[e] && pop_u[e]) || ((pop_h[e] || pop_u[e]) && !pop_ok[e]);
            mem_we[e]  = wr_ok[e] && !ep_rst[e];
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        for (int e = 0; e < NUM_EP; e++) begin
            if (ep_rst[e]) begin
                wptr_d[e]  = '0;
                rptr_d[e]  = '0;
                count_d[e] = '0;
                ovf_d[e]   = 1'b0;
                udf_d[e]   = 1'b0;
            end else begin
                wptr_d[e]  = wptr_q[e] + PTR_W'(wr_ok[e]);
                rptr_d[e]  = rptr_q[e] + PTR_W'(pop_ok[e]);
                count_d[e] = count_q[e] + OCC_W'(wr_ok[e]) - OCC_W'(pop_ok[e]);
                ovf_d[e]   = ovf_set[e] || (ovf_q[e] && !err_clr);
                udf_d[e]   = udf_set[e] || (udf_q[e] && !err_clr);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_EP; e++) begin
                wptr_q[e]  <= '0;
                rptr_q[e]  <= '0;
                count_q[e] <= '0;
            end
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_EP; e++) begin
            if (mem_we[e]) mem_q[ADDR_W'({EP_W'(e), wptr_q[e]})] <= wdata[e];
        end
    end

    always_comb begin
        rx_data          = '0;
        tx_packet_data   = '0;
        host_occupancy   = '0;
        buffer_occupancy = '0;
        occupancy_all    = '0;
        empty            = '0;
        full             = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            occupancy_all[e*OCC_W +: OCC_W] = count_q[e];
            empty[e] = (count_q[e] == '0);
            full[e]  = (count_q[e] == OCC_W'(DEPTH));
            if (host_hit[e]) begin
                host_occupancy = count_q[e];
                if (count_q[e] != '0) rx_data = mem_q[ADDR_W'({EP_W'(e), rptr_q[e]})];
            end
            if (usb_hit[e]) begin
                buffer_occupancy = count_q[e];
                if (count_q[e] != '0) tx_packet_data = mem_q[ADDR_W'({EP_W'(e), rptr_q[e]})];
            end
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule

// File: tb/tb_usb_ep_buffer.sv
// Scoreboard bench for usb_ep_buffer: per-endpoint expected-data queues plus
// expected error vectors, compared against the DUT outputs.
module tb_usb_ep_buffer;

    localparam int unsigned NUM_EP = 4;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OCC_W  = 7;
    localparam int unsigned EP_W   = 2;

    logic                    clk, rst;
    logic [EP_W-1:0]         host_ep, usb_ep;
    logic                    store_tx_data, get_rx_data, clear;
    logic                    store_rx_packet_data, get_tx_packet_data, flush, err_clr;
    logic [DATA_W-1:0]       tx_data, rx_packet_data, rx_data, tx_packet_data;
    logic [OCC_W-1:0]        host_occupancy, buffer_occupancy;
    logic [NUM_EP*OCC_W-1:0] occupancy_all;
    logic [NUM_EP-1:0]       empty, full, ovf_err, udf_err;

    usb_ep_buffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .host_ep(host_ep), .store_tx_data(store_tx_data), .tx_data(tx_data),
        .get_rx_data(get_rx_data), .rx_data(rx_data), .clear(clear),
        .usb_ep(usb_ep), .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data(rx_packet_data), .get_tx_packet_data(get_tx_packet_data),
        .tx_packet_data(tx_packet_data), .flush(flush), .err_clr(err_clr),
        .host_occupancy(host_occupancy), .buffer_occupancy(buffer_occupancy),
        .occupancy_all(occupancy_all), .empty(empty), .full(full),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] sb [NUM_EP][$];
    logic [NUM_EP-1:0] exp_ovf, exp_udf;
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        store_tx_data = 1'b0; get_rx_data = 1'b0; clear = 1'b0;
        store_rx_packet_data = 1'b0; get_tx_packet_data = 1'b0;
        flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_occ(input string tag, input int e);
        check_eq(tag, 32'(occupancy_all[e*OCC_W +: OCC_W]), 32'(sb[e].size()));
    endtask

    task automatic wr(input int e, input logic [DATA_W-1:0] d, input bit host);
        if (host) begin
            host_ep = EP_W'(e); tx_data = d; store_tx_data = 1'b1;
        end else begin
            usb_ep = EP_W'(e); rx_packet_data = d; store_rx_packet_data = 1'b1;
        end
        if (sb[e].size() == DEPTH) exp_ovf[e] = 1'b1;
        else sb[e].push_back(d);
        tick();
    endtask

    task automatic pop(input string tag, input int e, input bit host);
        logic [DATA_W-1:0] exp;
        if (host) host_ep = EP_W'(e);
        else usb_ep = EP_W'(e);
        #1;
        if (sb[e].size() == 0) begin
            exp = '0;
            exp_udf[e] = 1'b1;
        end else begin
            exp = sb[e].pop_front();
        end
        if (host) begin
            check_eq(tag, 32'(rx_data), 32'(exp));
            get_rx_data = 1'b1;
        end else begin
            check_eq(tag, 32'(tx_packet_data), 32'(exp));
            get_tx_packet_data = 1'b1;
        end
        tick();
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        exp_ovf = '0;
        exp_udf = '0;
        rst = 1'b1;
        host_ep = '0; usb_ep = '0; tx_data = '0; rx_packet_data = '0;
        idle();
        #12;
        check_eq("rst_empty", 32'(empty), 32'hF);
        check_eq("rst_full", 32'(full), 32'h0);
        check_eq("rst_occ_all", 32'(occupancy_all), 32'h0);
        check_eq("rst_ovf", 32'(ovf_err), 32'h0);
        check_eq("rst_udf", 32'(udf_err), 32'h0);
        check_eq("rst_rx_data", 32'(rx_data), 32'h0);
        rst = 1'b0;
        tick();

        // Basic host write, USB read on EP1
        wr(1, 8'h11, 1'b1);
        wr(1, 8'h22, 1'b1);
        wr(1, 8'h33, 1'b1);
        host_ep = 2'd1;
        #1;
        check_eq("t1_host_occ", 32'(host_occupancy), 32'd3);
        for (int i = 0; i < 3; i++) pop("t1_tx_data", 1, 1'b0);
        check_eq("t1_empty1", 32'(empty[1]), 32'd1);

        // Fill EP2, overflow, then write+pop at full
        for (int i = 0; i < DEPTH; i++) wr(2, 8'($urandom), 1'b0);
        check_eq("t2_full2", 32'(full[2]), 32'd1);
        check_occ("t2_occ_full", 2);
        wr(2, 8'hFE, 1'b0);
        check_occ("t2_occ_after_ovf", 2);
        check_eq("t2_ovf", 32'(ovf_err), 32'(exp_ovf));
        err_clr = 1'b1;
        exp_ovf = '0;
        tick();
        check_eq("t2_ovf_cleared", 32'(ovf_err), 32'h0);
        host_ep = 2'd2; usb_ep = 2'd2;
        tx_data = 8'hA5; store_tx_data = 1'b1; get_tx_packet_data = 1'b1;
        #1;
        d = sb[2].pop_front();
        check_eq("t2_head_at_full", 32'(tx_packet_data), 32'(d));
        sb[2].push_back(8'hA5);
        tick();
        check_occ("t2_occ_wr_pop", 2);
        check_eq("t2_no_new_ovf", 32'(ovf_err), 32'h0);
        for (int i = 0; i < DEPTH; i++) pop("t2_drain", 2, 1'b0);
        check_eq("t2_empty2", 32'(empty[2]), 32'd1);

        // Dual write on EP0: USB wins
        host_ep = 2'd0; usb_ep = 2'd0;
        tx_data = 8'hAA; store_tx_data = 1'b1;
        rx_packet_data = 8'h55; store_rx_packet_data = 1'b1;
        sb[0].push_back(8'h55);
        exp_ovf[0] = 1'b1;
        tick();
        check_occ("t3_occ0", 0);
        check_eq("t3_ovf", 32'(ovf_err), 32'(exp_ovf));
        check_eq("t3_others_empty", 32'(empty), 32'hE);
        pop("t3_head", 0, 1'b1);

        // Pop of empty EP3 with same-cycle write
        usb_ep = 2'd3; get_tx_packet_data = 1'b1;
        host_ep = 2'd3; tx_data = 8'h7E; store_tx_data = 1'b1;
        exp_udf[3] = 1'b1;
        sb[3].push_back(8'h7E);
        tick();
        check_eq("t4_udf", 32'(udf_err), 32'(exp_udf));
        check_occ("t4_occ3", 3);
        check_eq("t4_head", 32'(rx_data), 32'h7E);
        usb_ep = 2'd0; get_tx_packet_data = 1'b1; err_clr = 1'b1;
        exp_udf = 4'b0001;
        tick();
        check_eq("t4_set_beats_clr", 32'(udf_err), 32'(exp_udf));
        err_clr = 1'b1;
        exp_udf = '0; exp_ovf = '0;
        tick();
        check_eq("t4_udf_clr", 32'(udf_err), 32'h0);
        check_eq("t4_ovf_clr", 32'(ovf_err), 32'h0);
        pop("t4_pop3", 3, 1'b1);

        // Interleaved write/pop stream on EP1 with pointer wraparound
        for (int i = 0; i < 130; i++) begin
            usb_ep = 2'd1; host_ep = 2'd1;
            #1;
            if ((i % 3 != 0) && (sb[1].size() > 0)) begin
                d = sb[1].pop_front();
                check_eq("t5_stream", 32'(rx_data), 32'(d));
                get_rx_data = 1'b1;
            end
            rx_packet_data = 8'(i * 7 + 3);
            store_rx_packet_data = 1'b1;
            sb[1].push_back(8'(i * 7 + 3));
            tick();
            check_occ("t5_occ1", 1);
        end
        while (sb[1].size() > 0) pop("t5_drain", 1, 1'b1);
        check_eq("t5_no_err", 32'({ovf_err, udf_err}), 32'h0);

        // Flush overrides same-cycle write; async reset mid-burst
        for (int i = 0; i < 10; i++) wr(0, 8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 5; i++) wr(1, 8'(8'h80 + i), 1'b0);
        usb_ep = 2'd0; flush = 1'b1;
        host_ep = 2'd0; tx_data = 8'hEE; store_tx_data = 1'b1;
        sb[0].delete();
        tick();
        check_occ("t6_occ0_flushed", 0);
        check_occ("t6_occ1_kept", 1);
        wr(1, 8'h90, 1'b0);
        usb_ep = 2'd1; rx_packet_data = 8'h91; store_rx_packet_data = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        for (int e = 0; e < NUM_EP; e++) sb[e].delete();
        check_eq("t6_async_occ", 32'(occupancy_all), 32'h0);
        check_eq("t6_async_empty", 32'(empty), 32'hF);
        idle();
        #3;
        rst = 1'b0;
        tick();
        host_ep = 2'd1;
        #1;
        check_eq("t6_rx_after_rst", 32'(rx_data), 32'h0);
        check_eq("t6_hocc_after_rst", 32'(host_occupancy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
